// File: rtl/redmule_mx_stream_decoder_if.sv
// ---------------------------------------------------------------------------
// redmule_mx_stream_decoder_if
// Bundles the three streams around the MX-to-FP16 decoder:
//   mx_val_*  : packed FP8 element beat (DATA_W bits, element i at [8i+:8])
//   mx_exp_*  : E8M0 shared exponents, one byte per lane group
//   fp16_*    : FP16 output beat (NUM_LANES x BITW) plus last-beat marker
// Signal suffixes are given from the decoder's point of view.
// Modports:
//   slave  - the decoder (consumes mx_*, produces fp16_*)
//   master - the environment (produces mx_*, consumes fp16_*)
// ---------------------------------------------------------------------------
interface redmule_mx_stream_decoder_if #(
   parameter int unsigned DATA_W    = 256,
   parameter int unsigned NUM_LANES = 8,
   parameter int unsigned BITW      = 16
);
   localparam int unsigned NUM_GROUPS = (DATA_W / 8) / NUM_LANES;

   logic                        mx_val_valid_i;
   logic                        mx_val_ready_o;
   logic [DATA_W-1:0]           mx_val_data_i;
   logic                        mx_exp_valid_i;
   logic                        mx_exp_ready_o;
   logic [NUM_GROUPS*8-1:0]     mx_exp_data_i;
   logic                        fp16_valid_o;
   logic                        fp16_ready_i;
   logic [NUM_LANES*BITW-1:0]   fp16_data_o;
   logic                        fp16_last_o;

   modport slave (
      input  mx_val_valid_i, mx_val_data_i, mx_exp_valid_i, mx_exp_data_i, fp16_ready_i,
      output mx_val_ready_o, mx_exp_ready_o, fp16_valid_o, fp16_data_o, fp16_last_o
   );

   modport master (
      output mx_val_valid_i, mx_val_data_i, mx_exp_valid_i, mx_exp_data_i, fp16_ready_i,
      input  mx_val_ready_o, mx_exp_ready_o, fp16_valid_o, fp16_data_o, fp16_last_o
   );
endinterface

// File: rtl/redmule_mx_stream_decoder.sv
// ---------------------------------------------------------------------------
// redmule_mx_stream_decoder
// Streaming MX (microscaling) to FP16 decoder. Joins one FP8 element beat with
// its vector of E8M0 shared exponents, then emits the block as NUM_GROUPS
// consecutive FP16 beats of NUM_LANES lanes (one shared exponent per group).
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous active-high reset
//   fmt_i  - element format, 0 = E4M3, 1 = E5M2 (sampled on input handshake)
//   bus    - redmule_mx_stream_decoder_if.slave (mx_val, mx_exp, fp16 streams)
//   busy_o - high while a block is held
// Configuration macro:
//   REDMULE_MX_DEC_E5M2_EN - when defined, fmt_i selects E4M3/E5M2; when
//   undefined, the E5M2 decoder is not built and every block decodes as E4M3.
// ---------------------------------------------------------------------------
module redmule_mx_stream_decoder #(
   parameter int unsigned DATA_W    = 256,
   parameter int unsigned NUM_LANES = 8,
   parameter int unsigned BITW      = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          fmt_i,
   redmule_mx_stream_decoder_if.slave    bus,
   output logic                          busy_o
);
   localparam int unsigned NUM_ELEMS  = DATA_W / 8;
   localparam int unsigned NUM_GROUPS = NUM_ELEMS / NUM_LANES;
   localparam int unsigned GRP_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
   localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NUM_GROUPS - 1);

   if ((NUM_ELEMS % NUM_LANES) != 0) begin : g_bad_lanes
      $error("NUM_ELEMS must be a multiple of NUM_LANES");
   end
   if (BITW != 16) begin : g_bad_bitw
      $error("BITW must be 16");
   end

   typedef enum logic [0:0] {IDLE = 1'b0, EMIT = 1'b1} state_t;

   state_t                                       state_r, state_nxt_s;
   logic [GRP_W-1:0]                             grp_r, grp_nxt_s;
   logic [NUM_GROUPS-1:0][NUM_LANES-1:0][7:0]    val_r;
   logic [NUM_GROUPS-1:0][7:0]                   exp_r;
   logic                                         ready_s;
   logic                                         accept_s;
   logic [NUM_LANES-1:0][15:0]                   lanes_s;

   // Final FP16 assembly: saturate on exponent overflow, flush on underflow
   // (FP16 subnormals are never produced).
   function automatic logic [15:0] fp16_pack(input logic s, input logic signed [10:0] ex,
                                             input logic [9:0] mant);
      logic [15:0] res;
      if (ex >= 11'sd31)     res = {s, 15'h7BFF};
      else if (ex <= 11'sd0) res = {s, 15'h0000};
      else                   res = {s, ex[4:0], mant};
      return res;
   endfunction

   // E4M3 element (bias 7) scaled by 2^(x-127).
   function automatic logic [15:0] dec_e4m3(input logic [7:0] b, input logic [7:0] x);
      logic [3:0]         e;
      logic [2:0]         m;
      logic [1:0]         p;
      logic signed [10:0] ex;
      logic [9:0]         mant;
      logic [15:0]        res;
      e    = b[6:3];
      m    = b[2:0];
      p    = m[2] ? 2'd2 : (m[1] ? 2'd1 : 2'd0);
      ex   = 11'sd0;
      mant = 10'd0;
      if (x == 8'hFF)                     res = 16'h7E00;
      else if (e == 4'hF && m == 3'h7)    res = {b[7], 15'h7E00};
      else if (e == 4'h0 && m == 3'h0)    res = {b[7], 15'h0000};
      else if (e != 4'h0) begin
         ex   = $signed({7'd0, e}) + $signed({3'd0, x}) - 11'sd119;
         mant = {m, 7'd0};
         res  = fp16_pack(b[7], ex, mant);
      end else begin
         // subnormal: the leading one becomes the hidden bit, the rest is left-aligned
         ex   = $signed({9'd0, p}) + $signed({3'd0, x}) - 11'sd121;
         mant = {m, 7'd0} << (2'd3 - p);
         res  = fp16_pack(b[7], ex, mant);
      end
      return res;
   endfunction

`ifdef REDMULE_MX_DEC_E5M2_EN
   logic fmt_r;

   // E5M2 element (bias 15) scaled by 2^(x-127).
   function automatic logic [15:0] dec_e5m2(input logic [7:0] b, input logic [7:0] x);
      logic [4:0]         e;
      logic [1:0]         m;
      logic               p;
      logic signed [10:0] ex;
      logic [9:0]         mant;
      logic [15:0]        res;
      e    = b[6:2];
      m    = b[1:0];
      p    = m[1];
      ex   = 11'sd0;
      mant = 10'd0;
      if (x == 8'hFF)                     res = 16'h7E00;
      else if (e == 5'h1F && m == 2'h0)   res = {b[7], 15'h7C00};
      else if (e == 5'h1F)                res = {b[7], 15'h7E00};
      else if (e == 5'h00 && m == 2'h0)   res = {b[7], 15'h0000};
      else if (e != 5'h00) begin
         ex   = $signed({6'd0, e}) + $signed({3'd0, x}) - 11'sd127;
         mant = {m, 8'd0};
         res  = fp16_pack(b[7], ex, mant);
      end else begin
         ex   = $signed({10'd0, p}) + $signed({3'd0, x}) - 11'sd128;
         mant = {m, 8'd0} << (2'd2 - {1'b0, p});
         res  = fp16_pack(b[7], ex, mant);
      end
      return res;
   endfunction
`else
   logic fmt_unused_s;
   assign fmt_unused_s = fmt_i;
`endif

   // The next block can enter while the last beat of the current one leaves.
   assign ready_s  = (state_r == IDLE) |
                     ((state_r == EMIT) && (grp_r == LAST_GRP) && bus.fp16_ready_i);
   assign accept_s = bus.mx_val_valid_i && bus.mx_exp_valid_i && ready_s;

   // State, group counter and block storage.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r <= IDLE;
         grp_r   <= '0;
         val_r   <= '0;
         exp_r   <= '0;
`ifdef REDMULE_MX_DEC_E5M2_EN
         fmt_r   <= 1'b0;
`endif
      end else begin
         state_r <= state_nxt_s;
         grp_r   <= grp_nxt_s;
         if (accept_s) begin
            val_r <= bus.mx_val_data_i;
            exp_r <= bus.mx_exp_data_i;
`ifdef REDMULE_MX_DEC_E5M2_EN
            fmt_r <= fmt_i;
`endif
         end else begin
            val_r <= val_r;
            exp_r <= exp_r;
         end
      end
   end

   // Next-state and group-counter logic.
   always_comb begin
      state_nxt_s = state_r;
      grp_nxt_s   = grp_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_nxt_s = EMIT;
               grp_nxt_s   = '0;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         EMIT: begin
            if (accept_s) begin
               // only possible on the last-beat handshake: reload without a bubble
               state_nxt_s = EMIT;
               grp_nxt_s   = '0;
            end else if (bus.fp16_ready_i) begin
               if (grp_r == LAST_GRP) begin
                  state_nxt_s = IDLE;
               end else begin
                  grp_nxt_s = grp_r + GRP_W'(1);
               end
            end else begin
               grp_nxt_s = grp_r;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            grp_nxt_s   = '0;
         end
      endcase
   end

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
`ifdef REDMULE_MX_DEC_E5M2_EN
      assign lanes_s[l] = fmt_r ? dec_e5m2(val_r[grp_r][l], exp_r[grp_r])
                                : dec_e4m3(val_r[grp_r][l], exp_r[grp_r]);
`else
      assign lanes_s[l] = dec_e4m3(val_r[grp_r][l], exp_r[grp_r]);
`endif
   end

   assign bus.mx_val_ready_o = ready_s;
   assign bus.mx_exp_ready_o = ready_s;
   assign bus.fp16_valid_o   = (state_r == EMIT);
   assign bus.fp16_last_o    = (state_r == EMIT) && (grp_r == LAST_GRP);
   assign bus.fp16_data_o    = lanes_s;
   assign busy_o             = (state_r == EMIT);
endmodule

// File: tb/tb_redmule_mx_stream_decoder.sv
`timescale 1ns/1ps
module tb_redmule_mx_stream_decoder;
   localparam int DATA_W    = 256;
   localparam int NUM_LANES = 8;
   localparam int BITW      = 16;
   localparam int NG        = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic fmt = 1'b0;
   logic busy;

   int errors = 0;
   int checks = 0;

   logic [7:0]   elem [NG][NUM_LANES];
   logic [7:0]   xs   [NG];
   logic [15:0]  expl [NG][NUM_LANES];
   logic [127:0] a_beats [NG];

   redmule_mx_stream_decoder_if #(.DATA_W(DATA_W), .NUM_LANES(NUM_LANES), .BITW(BITW)) bus ();

   redmule_mx_stream_decoder #(.DATA_W(DATA_W), .NUM_LANES(NUM_LANES), .BITW(BITW)) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .fmt_i  (fmt),
      .bus    (bus),
      .busy_o (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // lanes repeat the 4-entry pattern e0..e3 with expected results o0..o3
   task automatic fill4(input int g, input logic [7:0] x,
                        input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3,
                        input logic [15:0] o0, input logic [15:0] o1, input logic [15:0] o2, input logic [15:0] o3);
      xs[g] = x;
      for (int l = 0; l < NUM_LANES; l++) begin
         case (l % 4)
            0:       begin elem[g][l] = e0; expl[g][l] = o0; end
            1:       begin elem[g][l] = e1; expl[g][l] = o1; end
            2:       begin elem[g][l] = e2; expl[g][l] = o2; end
            default: begin elem[g][l] = e3; expl[g][l] = o3; end
         endcase
      end
   endtask

   task automatic set_lane(input int g, input int l, input logic [7:0] e, input logic [15:0] o);
      elem[g][l] = e;
      expl[g][l] = o;
   endtask

   task automatic load_block();
      for (int g = 0; g < NG; g++) begin
         bus.mx_exp_data_i[g*8 +: 8] = xs[g];
         for (int l = 0; l < NUM_LANES; l++)
            bus.mx_val_data_i[(g*NUM_LANES + l)*8 +: 8] = elem[g][l];
      end
   endtask

   function automatic logic [127:0] beat(input int g);
      logic [127:0] r;
      for (int l = 0; l < NUM_LANES; l++) r[16*l +: 16] = expl[g][l];
      return r;
   endfunction

   task automatic fill_basic();
      for (int g = 0; g < NG; g++)
         fill4(g, 8'd127, 8'h38, 8'h3C, 8'hB8, 8'h00, 16'h3C00, 16'h3E00, 16'hBC00, 16'h0000);
   endtask

   task automatic fill_scale();
      fill4(0, 8'd120, 8'h38, 8'h38, 8'h38, 8'h38, 16'h2000, 16'h2000, 16'h2000, 16'h2000);
      fill4(1, 8'd124, 8'h38, 8'h38, 8'h38, 8'h38, 16'h3000, 16'h3000, 16'h3000, 16'h3000);
      fill4(2, 8'd128, 8'h38, 8'h38, 8'h38, 8'h38, 16'h4000, 16'h4000, 16'h4000, 16'h4000);
      fill4(3, 8'd132, 8'h38, 8'h38, 8'h38, 8'h38, 16'h5000, 16'h5000, 16'h5000, 16'h5000);
   endtask

   // offer the block in IDLE with fp16_ready=1 and check all beats back to back
   task automatic run_block(input string tag);
      bus.fp16_ready_i = 1'b1;
      load_block();
      bus.mx_val_valid_i = 1'b1;
      bus.mx_exp_valid_i = 1'b1;
      #1;
      chk({tag, "_in_rdy"}, bus.mx_val_ready_o, 1'b1);
      @(negedge clk);
      bus.mx_val_valid_i = 1'b0;
      bus.mx_exp_valid_i = 1'b0;
      for (int g = 0; g < NG; g++) begin
         chk($sformatf("%s_valid%0d", tag, g), bus.fp16_valid_o, 1'b1);
         chk($sformatf("%s_last%0d", tag, g), bus.fp16_last_o, (g == NG-1));
         chk($sformatf("%s_data%0d", tag, g), bus.fp16_data_o, beat(g));
         @(negedge clk);
      end
      chk({tag, "_idle"}, bus.fp16_valid_o, 1'b0);
   endtask

   initial begin
      int g;
      int k;
      bus.mx_val_valid_i = 1'b0;
      bus.mx_exp_valid_i = 1'b0;
      bus.mx_val_data_i  = '0;
      bus.mx_exp_data_i  = '0;
      bus.fp16_ready_i   = 1'b1;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_valid", bus.fp16_valid_o, 1'b0);
      chk("rst_data",  bus.fp16_data_o, 128'h0);
      chk("rst_last",  bus.fp16_last_o, 1'b0);
      chk("rst_busy",  busy, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_val_rdy", bus.mx_val_ready_o, 1'b1);
      chk("rst_exp_rdy", bus.mx_exp_ready_o, 1'b1);

      // basic E4M3
      fill_basic();
      run_block("basic");

      // per-group scale
      fill_scale();
      run_block("scale");

      // boundary cases
      fill4(0, 8'd150, 8'h7E, 8'hFE, 8'h7E, 8'hFE, 16'h7BFF, 16'hFBFF, 16'h7BFF, 16'hFBFF);
      fill4(1, 8'd100, 8'h38, 8'hB8, 8'h38, 8'hB8, 16'h0000, 16'h8000, 16'h0000, 16'h8000);
      fill4(2, 8'd127, 8'h01, 8'h7F, 8'hFF, 8'h08, 16'h1800, 16'h7E00, 16'hFE00, 16'h2400);
      set_lane(2, 4, 8'h06, 16'h2200);
      set_lane(2, 5, 8'h86, 16'hA200);
      set_lane(2, 6, 8'h02, 16'h1C00);
      fill4(3, 8'hFF, 8'hFF, 8'h38, 8'h00, 8'h80, 16'h7E00, 16'h7E00, 16'h7E00, 16'h7E00);
      run_block("bound");

      // fmt_i=1: E5M2 when compiled in, otherwise still E4M3
`ifdef REDMULE_MX_DEC_E5M2_EN
      fill4(0, 8'd127, 8'h3C, 8'h7C, 8'h7D, 8'h40, 16'h3C00, 16'h7C00, 16'h7E00, 16'h4000);
      set_lane(0, 4, 8'hBC, 16'hBC00);
      set_lane(0, 5, 8'hFC, 16'hFC00);
      set_lane(0, 6, 8'h00, 16'h0000);
      fill4(1, 8'd129, 8'h03, 8'h01, 8'h00, 8'h80, 16'h0A00, 16'h0400, 16'h0000, 16'h8000);
`else
      fill4(0, 8'd127, 8'h3C, 8'h7C, 8'h7D, 8'h40, 16'h3E00, 16'h5E00, 16'h5E80, 16'h4000);
      set_lane(0, 4, 8'hBC, 16'hBE00);
      set_lane(0, 5, 8'hFC, 16'hDE00);
      set_lane(0, 6, 8'h00, 16'h0000);
      fill4(1, 8'd129, 8'h03, 8'h01, 8'h00, 8'h80, 16'h2600, 16'h2000, 16'h0000, 16'h8000);
`endif
      fill4(2, 8'd160, 8'h7B, 8'h7B, 8'h7B, 8'h7B, 16'h7BFF, 16'h7BFF, 16'h7BFF, 16'h7BFF);
      fill4(3, 8'd100, 8'h04, 8'h84, 8'h04, 8'h84, 16'h0000, 16'h8000, 16'h0000, 16'h8000);
      fmt = 1'b1;
      run_block("fmt1");
      fmt = 1'b0;

      // backpressure: ready pattern 1,0,0,1 with input data scrambled while busy
      fill_basic();
      load_block();
      bus.mx_val_valid_i = 1'b1;
      bus.mx_exp_valid_i = 1'b1;
      @(negedge clk);
      bus.mx_val_valid_i = 1'b0;
      bus.mx_exp_valid_i = 1'b0;
      bus.mx_val_data_i  = {DATA_W{1'b1}};
      bus.mx_exp_data_i  = 32'h5A5A5A5A;
      g = 0;
      k = 0;
      while (g < NG && k < 40) begin
         bus.fp16_ready_i = ((k % 4) == 1 || (k % 4) == 2) ? 1'b0 : 1'b1;
         #1;
         chk($sformatf("bp_valid_k%0d", k), bus.fp16_valid_o, 1'b1);
         chk($sformatf("bp_data_k%0d", k), bus.fp16_data_o, beat(g));
         chk($sformatf("bp_last_k%0d", k), bus.fp16_last_o, (g == NG-1));
         chk($sformatf("bp_in_rdy_k%0d", k), bus.mx_val_ready_o, (g == NG-1) && bus.fp16_ready_i);
         @(posedge clk);
         if (bus.fp16_ready_i) g++;
         k++;
         @(negedge clk);
      end
      chk("bp_beats", g, NG);
      bus.fp16_ready_i = 1'b1;
      #1;
      chk("bp_idle", bus.fp16_valid_o, 1'b0);

      // back-to-back: block B offered from beat 1 of block A, taken on A's last beat
      @(negedge clk);
      fill_scale();
      for (int i = 0; i < NG; i++) a_beats[i] = beat(i);
      load_block();
      bus.mx_val_valid_i = 1'b1;
      bus.mx_exp_valid_i = 1'b1;
      @(negedge clk);
      bus.mx_val_valid_i = 1'b0;
      bus.mx_exp_valid_i = 1'b0;
      for (int i = 0; i < NG; i++) begin
         if (i == 1) begin
            fill_basic();
            load_block();
            bus.mx_val_valid_i = 1'b1;
            bus.mx_exp_valid_i = 1'b1;
         end
         #1;
         chk($sformatf("b2b_a_data%0d", i), bus.fp16_data_o, a_beats[i]);
         chk($sformatf("b2b_a_in_rdy%0d", i), bus.mx_val_ready_o, (i == NG-1));
         chk($sformatf("b2b_a_exp_rdy%0d", i), bus.mx_exp_ready_o, (i == NG-1));
         @(negedge clk);
      end
      bus.mx_val_valid_i = 1'b0;
      bus.mx_exp_valid_i = 1'b0;
      for (int i = 0; i < NG; i++) begin
         chk($sformatf("b2b_b_valid%0d", i), bus.fp16_valid_o, 1'b1);
         chk($sformatf("b2b_b_data%0d", i), bus.fp16_data_o, beat(i));
         chk($sformatf("b2b_b_last%0d", i), bus.fp16_last_o, (i == NG-1));
         @(negedge clk);
      end
      chk("b2b_idle", bus.fp16_valid_o, 1'b0);

      // a single valid never consumes
      bus.mx_val_valid_i = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("solo_val_valid", bus.fp16_valid_o, 1'b0);
         chk("solo_val_busy", busy, 1'b0);
      end
      bus.mx_val_valid_i = 1'b0;
      bus.mx_exp_valid_i = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("solo_exp_valid", bus.fp16_valid_o, 1'b0);
      end
      bus.mx_exp_valid_i = 1'b0;

      // reset mid-block, then a fresh block starts at group 0
      fill_basic();
      load_block();
      bus.mx_val_valid_i = 1'b1;
      bus.mx_exp_valid_i = 1'b1;
      @(negedge clk);
      bus.mx_val_valid_i = 1'b0;
      bus.mx_exp_valid_i = 1'b0;
      chk("mid_beat0", bus.fp16_data_o, beat(0));
      @(negedge clk);
      chk("mid_beat1", bus.fp16_data_o, beat(1));
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_valid", bus.fp16_valid_o, 1'b0);
      chk("mid_rst_data",  bus.fp16_data_o, 128'h0);
      chk("mid_rst_last",  bus.fp16_last_o, 1'b0);
      chk("mid_rst_busy",  busy, 1'b0);
      rst = 1'b0;
      fill_scale();
      run_block("fresh");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
